aes_cone_launch_capture: RTL

Launch/capture pipeline stage that wraps one combinational AES timing cone (12 inputs, 1 output). It registers a tagged input vector and drives it unchanged onto the cone inputs. One cycle later it samples the cone output into a result register, behind valid/ready handshakes. It also compares each result against an expected bit carried with the vector and keeps saturating sample, ones and mismatch counters for silicon/netlist characterisation.

---
 rtl/aes_cone_launch_capture.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/aes_cone_launch_capture.sv
// Launch/capture wrapper around one combinational AES cone: registered launch vector, sampled result, counters.
// Latency: 2 edges from input handshake to res_valid_o; 1 vector/cycle when res_ready_i is held high.
// Backpressure: res_ready_i low stalls both stages; in_ready_o is combinational from res_ready_i.
module aes_cone_launch_capture #(
  parameter int WIDTH = 12,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_vec_i,
  input  logic [TAG_W-1:0] in_tag_i,
  input  logic             in_exp_i,
  output logic [WIDTH-1:0] cone_in_o,
  input  logic             cone_out_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_bit_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic             res_err_o,
  input  logic             clr_i,
  output logic [CNT_W-1:0] sample_cnt_o,
  output logic [CNT_W-1:0] ones_cnt_o,
  output logic [CNT_W-1:0] mism_cnt_o,
  output logic             err_sticky_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Launch stage: cone_in_q feeds the cone port directly, no logic after the flop.
  logic             l_valid_q, l_valid_d;
  logic [WIDTH-1:0] cone_in_q, cone_in_d;
  logic [TAG_W-1:0] l_tag_q, l_tag_d;
  logic             l_exp_q, l_exp_d;

  // Capture stage.
  logic             res_valid_q, res_valid_d;
  logic             res_bit_q, res_bit_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_err_q, res_err_d;

  // Characterisation counters.
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
  logic [CNT_W-1:0] mism_cnt_q, mism_cnt_d;
  logic             err_sticky_q, err_sticky_d;

  logic adv_c;
  logic adv_l;
  logic res_acc;

  // Handshake: C moves when empty or drained; L moves when empty or C moves.
  always_comb begin
    adv_c   = !res_valid_q || res_ready_i;
    adv_l   = !l_valid_q || adv_c;
    res_acc = res_valid_q && res_ready_i;
  end

  // Launch next-state: cone_in keeps its last value when idle so the cone does not toggle.
  always_comb begin
    l_valid_d = l_valid_q;
    cone_in_d = cone_in_q;
    l_tag_d   = l_tag_q;
    l_exp_d   = l_exp_q;
    if (in_valid_i && adv_l) begin
      l_valid_d = 1'b1;
      cone_in_d = in_vec_i;
      l_tag_d   = in_tag_i;
      l_exp_d   = in_exp_i;
    end else if (adv_l) begin
      l_valid_d = 1'b0;
    end
  end

  // Capture next-state: the cone has had a full period since L was loaded; empty L only clears valid.
  always_comb begin
    res_valid_d = res_valid_q;
    res_bit_d   = res_bit_q;
    res_tag_d   = res_tag_q;
    res_err_d   = res_err_q;
    if (adv_c) begin
      res_valid_d = l_valid_q;
      if (l_valid_q) begin
        res_bit_d = cone_out_i;
        res_tag_d = l_tag_q;
        res_err_d = cone_out_i ^ l_exp_q;
      end
    end
  end

  // Counter next-state: saturate at all-ones; clr beats a same-cycle increment.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    mism_cnt_d   = mism_cnt_q;
    err_sticky_d = err_sticky_q;
    if (clr_i) begin
      sample_cnt_d = '0;
      ones_cnt_d   = '0;
      mism_cnt_d   = '0;
      err_sticky_d = 1'b0;
    end else if (res_acc) begin
      if (sample_cnt_q != CNT_MAX) sample_cnt_d = sample_cnt_q + CNT_ONE;
      if (res_bit_q && (ones_cnt_q != CNT_MAX)) ones_cnt_d = ones_cnt_q + CNT_ONE;
      if (res_err_q && (mism_cnt_q != CNT_MAX)) mism_cnt_d = mism_cnt_q + CNT_ONE;
      if (res_err_q) err_sticky_d = 1'b1;
    end
  end

  // Pipeline registers; reset drops any in-flight vector.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      l_valid_q   <= 1'b0;
      cone_in_q   <= '0;
      l_tag_q     <= '0;
      l_exp_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_bit_q   <= 1'b0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      l_valid_q   <= l_valid_d;
      cone_in_q   <= cone_in_d;
      l_tag_q     <= l_tag_d;
      l_exp_q     <= l_exp_d;
      res_valid_q <= res_valid_d;
      res_bit_q   <= res_bit_d;
      res_tag_q   <= res_tag_d;
      res_err_q   <= res_err_d;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_cnt_q <= '0;
      ones_cnt_q   <= '0;
      mism_cnt_q   <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      mism_cnt_q   <= mism_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign in_ready_o   = adv_l;
  assign cone_in_o    = cone_in_q;
  assign res_valid_o  = res_valid_q;
  assign res_bit_o    = res_bit_q;
  assign res_tag_o    = res_tag_q;
  assign res_err_o    = res_err_q;
  assign sample_cnt_o = sample_cnt_q;
  assign ones_cnt_o   = ones_cnt_q;
  assign mism_cnt_o   = mism_cnt_q;
  assign err_sticky_o = err_sticky_q;

endmodule
